// File: rtl/subleq_pkg.sv
// -----------------------------------------------------------------------------
// subleq_pkg
//   Shared types and helpers for the SUBLEQ sequencer.
//   - State encoding constants and the state_t enum that uses them.
//   - halt_addr(): the all-ones address that stops the sequencer.
//   No ports (package).
// -----------------------------------------------------------------------------
package subleq_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_FETCH_A = 3'd1;
   localparam logic [2:0] ST_FETCH_B = 3'd2;
   localparam logic [2:0] ST_FETCH_C = 3'd3;
   localparam logic [2:0] ST_LOAD_A  = 3'd4;
   localparam logic [2:0] ST_LOAD_B  = 3'd5;
   localparam logic [2:0] ST_WRITE_B = 3'd6;
   localparam logic [2:0] ST_HALT    = 3'd7;

   typedef enum logic [2:0] {
      IDLE    = ST_IDLE,
      FETCH_A = ST_FETCH_A,
      FETCH_B = ST_FETCH_B,
      FETCH_C = ST_FETCH_C,
      LOAD_A  = ST_LOAD_A,
      LOAD_B  = ST_LOAD_B,
      WRITE_B = ST_WRITE_B,
      HALT    = ST_HALT
   } state_t;

   // All-ones value in the low addr_w bits (addr_w up to 32).
   function automatic logic [31:0] halt_addr(input int unsigned addr_w);
      if (addr_w >= 32) begin
         return '1;
      end
      return (32'd1 << addr_w) - 32'd1;
   endfunction

endpackage

// File: rtl/subleq_mem_port.sv
// -----------------------------------------------------------------------------
// subleq_mem_port
//   Registered request side of the shared memory port. While i_start is high
//   and no request is outstanding, one request is launched on the next edge
//   with we/addr/wdata frozen until the slave acks. The request drops on the
//   ack edge, which leaves exactly one idle cycle before the next launch.
// Ports
//   clkIn, rst         clock, synchronous active-high reset
//   i_start            FSM is in an access state
//   i_we/i_addr/i_wdata access to launch
//   o_done             ack accepted this cycle (comb: req & ack)
//   o_rdata            read data for the FSM to capture on o_done
//   o_mem_*            memory request outputs
//   i_mem_rdata/i_mem_ack memory response inputs
// -----------------------------------------------------------------------------
module subleq_mem_port
   import subleq_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
)(
   input  logic              clkIn,
   input  logic              rst,
   input  logic              i_start,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic              o_done,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_mem_req,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata,
   input  logic              i_mem_ack
);

   logic              r_req;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;

   always_ff @(posedge clkIn) begin
      if (rst) begin
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (r_req) begin
         // Ack closes the access; ack while idle is never looked at.
         if (i_mem_ack) begin
            r_req <= 1'b0;
         end
      end else if (i_start) begin
         r_req   <= 1'b1;
         r_we    <= i_we;
         r_addr  <= i_addr;
         r_wdata <= i_wdata;
      end
   end

   assign o_done      = r_req & i_mem_ack;
   assign o_rdata     = i_mem_rdata;
   assign o_mem_req   = r_req;
   assign o_mem_we    = r_we;
   assign o_mem_addr  = r_addr;
   assign o_mem_wdata = r_wdata;

endmodule

// File: rtl/subleq_sequencer.sv
// -----------------------------------------------------------------------------
// subleq_sequencer
//   Single-clock SUBLEQ sequencer: mem[b] -= mem[a]; if result <= 0 jump to c.
//   Six memory accesses per instruction through one req/ack port
//   (subleq_mem_port). Reaching the all-ones address halts until reset.
// Ports
//   clkIn, rst      clock, synchronous active-high reset
//   run             start / continue; sampled in IDLE and at instruction end
//   mem_req/we/addr/wdata  memory request, stable until ack
//   mem_rdata/mem_ack      memory response
//   pc              current/next instruction address
//   halted          sequencer is in HALT
//   instr_count     (only with SUBLEQ_INSTR_COUNT_EN) completed instructions
// Build option
//   SUBLEQ_INSTR_COUNT_EN : adds the 32-bit instruction counter port.
// -----------------------------------------------------------------------------
module subleq_sequencer
   import subleq_pkg::*;
#(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
)(
   input  logic              clkIn,
   input  logic              rst,
   input  logic              run,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [ADDR_W-1:0] pc,
   output logic              halted
`ifdef SUBLEQ_INSTR_COUNT_EN
   ,
   output logic [31:0]       instr_count
`endif
);

   localparam logic [ADDR_W-1:0] HALT_ADDR = ADDR_W'(halt_addr(ADDR_W));

   state_t                   r_state;
   state_t                   w_next_state;
   logic [ADDR_W-1:0]        r_pc;
   logic [ADDR_W-1:0]        r_a;
   logic [ADDR_W-1:0]        r_b;
   logic [ADDR_W-1:0]        r_c;
   logic signed [DATA_W-1:0] r_opa;
   logic signed [DATA_W-1:0] r_opb;
   logic signed [DATA_W-1:0] w_res;
   logic                     w_leq;
   logic [ADDR_W-1:0]        w_next_pc;
   logic                     w_done;
   logic [DATA_W-1:0]        w_rdata;
   logic                     w_access;
   logic                     w_we;
   logic [ADDR_W-1:0]        w_addr;
   logic [DATA_W-1:0]        w_wdata;

   function automatic logic is_leq(input logic signed [DATA_W-1:0] v);
      return v[DATA_W-1] | (v == '0);
   endfunction

   // Operand words are addresses in their low ADDR_W bits.
   function automatic logic [ADDR_W-1:0] to_addr(input logic [DATA_W-1:0] w);
      return ADDR_W'(w);
   endfunction

   assign w_res     = r_opb - r_opa;
   assign w_leq     = is_leq(w_res);
   assign w_next_pc = w_leq ? r_c : (r_pc + ADDR_W'(3));

   // State register
   always_ff @(posedge clkIn) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic: access states advance only on an accepted ack
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (run)    w_next_state = FETCH_A;
         FETCH_A: if (w_done) w_next_state = FETCH_B;
         FETCH_B: if (w_done) w_next_state = FETCH_C;
         FETCH_C: if (w_done) w_next_state = LOAD_A;
         LOAD_A:  if (w_done) w_next_state = LOAD_B;
         LOAD_B:  if (w_done) w_next_state = WRITE_B;
         WRITE_B: begin
            if (w_done) begin
               if (w_next_pc == HALT_ADDR) begin
                  w_next_state = HALT;
               end else if (run) begin
                  w_next_state = FETCH_A;
               end else begin
                  w_next_state = IDLE;
               end
            end
         end
         HALT:    w_next_state = HALT;
         default: w_next_state = IDLE;
      endcase
   end

   // Output logic: which access the current state wants
   always_comb begin
      w_access = 1'b0;
      w_we     = 1'b0;
      w_addr   = '0;
      w_wdata  = w_res;
      halted   = (r_state == HALT);
      case (r_state)
         FETCH_A: begin w_access = 1'b1; w_addr = r_pc;                 end
         FETCH_B: begin w_access = 1'b1; w_addr = r_pc + ADDR_W'(1);    end
         FETCH_C: begin w_access = 1'b1; w_addr = r_pc + ADDR_W'(2);    end
         LOAD_A:  begin w_access = 1'b1; w_addr = r_a;                  end
         LOAD_B:  begin w_access = 1'b1; w_addr = r_b;                  end
         WRITE_B: begin w_access = 1'b1; w_addr = r_b; w_we = 1'b1;     end
         default: ;
      endcase
   end

   // Datapath registers, loaded on the ack edge of their access
   always_ff @(posedge clkIn) begin
      if (rst) begin
         r_pc  <= RESET_PC;
         r_a   <= '0;
         r_b   <= '0;
         r_c   <= '0;
         r_opa <= '0;
         r_opb <= '0;
      end else if (w_done) begin
         case (r_state)
            FETCH_A: r_a   <= to_addr(w_rdata);
            FETCH_B: r_b   <= to_addr(w_rdata);
            FETCH_C: r_c   <= to_addr(w_rdata);
            LOAD_A:  r_opa <= w_rdata;
            LOAD_B:  r_opb <= w_rdata;
            WRITE_B: r_pc  <= w_next_pc;
            default: ;
         endcase
      end
   end

`ifdef SUBLEQ_INSTR_COUNT_EN
   logic [31:0] r_instr_count;

   // Counts every completed write-back, including the one that halts.
   always_ff @(posedge clkIn) begin
      if (rst) begin
         r_instr_count <= '0;
      end else if (w_done && (r_state == WRITE_B)) begin
         r_instr_count <= r_instr_count + 32'd1;
      end
   end

   assign instr_count = r_instr_count;
`endif

   assign pc = r_pc;

   subleq_mem_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_mem_port (
      .clkIn       (clkIn),
      .rst         (rst),
      .i_start     (w_access),
      .i_we        (w_we),
      .i_addr      (w_addr),
      .i_wdata     (w_wdata),
      .o_done      (w_done),
      .o_rdata     (w_rdata),
      .o_mem_req   (mem_req),
      .o_mem_we    (mem_we),
      .o_mem_addr  (mem_addr),
      .o_mem_wdata (mem_wdata),
      .i_mem_rdata (mem_rdata),
      .i_mem_ack   (mem_ack)
   );

endmodule

// File: tb/tb_subleq_sequencer.sv
// -----------------------------------------------------------------------------
// tb_subleq_sequencer
//   Directed bench for subleq_sequencer with a behavioural memory slave
//   (zero-wait or random 0-5 cycle ack) and a request-stability monitor.
// -----------------------------------------------------------------------------
module tb_subleq_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_ack;
   logic [15:0] pc;
   logic        halted;
`ifdef SUBLEQ_INSTR_COUNT_EN
   logic [31:0] instr_count;
`endif

   always #5 clk = ~clk;

   subleq_sequencer #(
      .DATA_W   (16),
      .ADDR_W   (16),
      .RESET_PC (16'h0000)
   ) dut (
      .clkIn     (clk),
      .rst       (rst),
      .run       (run),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .pc        (pc),
      .halted    (halted)
`ifdef SUBLEQ_INSTR_COUNT_EN
      ,
      .instr_count (instr_count)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- memory slave ----------------
   logic [15:0] mem [0:65535];
   logic [15:0] ld_addr [16];
   logic [15:0] ld_data [16];
   int          ld_n      = 0;
   bit          do_load   = 1'b0;
   bit          rnd_mode  = 1'b0;
   bit          spur      = 1'b0;
   int          cyc       = 0;
   int          acc_cnt   = 0;
   int          wr_cnt    = 0;
   int          wr_cyc    = 0;
   logic [15:0] wr_addr   = '0;
   logic [15:0] wr_data   = '0;
   int          wcnt      = 0;
   int          cur_delay = 0;

   assign mem_rdata = mem[mem_addr];
   // Spurious acks are thrown at the DUT only while it is not requesting.
   assign mem_ack   = mem_req ? (wcnt >= cur_delay) : spur;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (do_load) begin
         for (int i = 0; i < 65536; i++) mem[i] <= '0;
         for (int i = 0; i < ld_n; i++) mem[ld_addr[i]] <= ld_data[i];
      end
      if (rst) begin
         wcnt      <= 0;
         cur_delay <= 0;
      end else if (mem_req && mem_ack) begin
         acc_cnt <= acc_cnt + 1;
         if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= mem_addr;
            wr_data <= mem_wdata;
            wr_cyc  <= cyc;
         end
         wcnt      <= 0;
         cur_delay <= rnd_mode ? int'($urandom_range(0, 5)) : 0;
      end else if (mem_req) begin
         wcnt <= wcnt + 1;
      end
   end

   // ---------------- request stability monitor ----------------
   logic        p_req   = 1'b0;
   logic        p_ack   = 1'b0;
   logic        p_we    = 1'b0;
   logic [15:0] p_addr  = '0;
   logic [15:0] p_wdata = '0;

   always @(negedge clk) begin
      if (rst) begin
         p_req <= 1'b0;
      end else begin
         if (p_req && !p_ack && mem_req) begin
            check("hold_addr", mem_addr, p_addr);
            check("hold_we", mem_we, p_we);
            if (mem_we) check("hold_wdata", mem_wdata, p_wdata);
         end
         if (p_req && p_ack) check("gap_after_ack", mem_req, 0);
         p_req   <= mem_req;
         p_ack   <= mem_ack;
         p_we    <= mem_we;
         p_addr  <= mem_addr;
         p_wdata <= mem_wdata;
      end
      spur <= rnd_mode ? 1'($urandom_range(0, 1)) : 1'b0;
   end

   // ---------------- helpers ----------------
   task automatic put(input logic [15:0] a, input logic [15:0] d);
      ld_addr[ld_n] = a;
      ld_data[ld_n] = d;
      ld_n++;
   endtask

   task automatic load();
      do_load = 1'b1;
      @(negedge clk);
      do_load = 1'b0;
      ld_n    = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      run = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_wr(input int w0, input string tag);
      for (int i = 0; i < 1000; i++) begin
         if (wr_cnt != w0) break;
         @(negedge clk);
      end
      check(tag, 32'(wr_cnt != w0), 1);
   endtask

   task automatic wait_halt(input string tag);
      for (int i = 0; i < 1500; i++) begin
         if (halted) break;
         @(negedge clk);
      end
      check(tag, 32'(halted), 1);
   endtask

   // One instruction with run pulsed for a single cycle; returns cycles
   // from the run-sampling edge to the write-back edge.
   task automatic run_one(input string tag, output int delta);
      int t0;
      int w0;
      w0  = wr_cnt;
      t0  = cyc;
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      wait_wr(w0, tag);
      delta = wr_cyc - t0;
   endtask

   task automatic prog_basic(input logic [15:0] m4, input logic [15:0] m5);
      put(16'd0, 16'd4);
      put(16'd1, 16'd5);
      put(16'd2, 16'd9);
      put(16'd4, m4);
      put(16'd5, m5);
      load();
   endtask

   task automatic prog_multi();
      put(16'd0, 16'd20); put(16'd1, 16'd21); put(16'd2, 16'd6);
      put(16'd3, 16'd20); put(16'd4, 16'd22); put(16'd5, 16'd9);
      put(16'd9, 16'd23); put(16'd10, 16'd23); put(16'd11, 16'hFFFF);
      put(16'd20, 16'd2); put(16'd21, 16'd5); put(16'd22, 16'd1); put(16'd23, 16'd7);
      load();
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int delta;
      int w0;
      int a0;
      int reqs;

      rst = 1'b1;
      run = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // 1) reset while a request is outstanding, then first-request latency
      prog_basic(16'd3, 16'd7);
      run = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (mem_req) break;
         @(negedge clk);
      end
      check("t1_req_before_rst", mem_req, 1);
      rst = 1'b1;
      run = 1'b0;
      @(negedge clk);
      check("t1_rst_req", mem_req, 0);
      check("t1_rst_we", mem_we, 0);
      check("t1_rst_addr", mem_addr, 0);
      check("t1_rst_wdata", mem_wdata, 0);
      check("t1_rst_pc", pc, 0);
      check("t1_rst_halted", halted, 0);
      rst = 1'b0;
      @(negedge clk);
      w0  = wr_cnt;
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      check("t1_req_after_1", mem_req, 0);
      @(negedge clk);
      check("t1_req_after_2", mem_req, 1);
      check("t1_first_addr", mem_addr, 0);
      check("t1_first_we", mem_we, 0);
      wait_wr(w0, "t1_complete");

      // 2) not-taken instruction, zero-wait: 12 cycles
      do_reset();
      prog_basic(16'd3, 16'd7);
      run_one("t2_complete", delta);
      check("t2_cycles", delta, 12);
      check("t2_waddr", wr_addr, 5);
      check("t2_wdata", wr_data, 4);
      check("t2_mem5", mem[5], 4);
      check("t2_pc", pc, 3);
      check("t2_halted", halted, 0);

      // 3) negative result, branch taken
      do_reset();
      prog_basic(16'd7, 16'd3);
      run_one("t3_complete", delta);
      check("t3_cycles", delta, 12);
      check("t3_mem5", mem[5], 16'hFFFC);
      check("t3_pc", pc, 9);

      // a == b (zero result, taken) into the top of memory, then pc+3 wraps
      do_reset();
      put(16'd0, 16'd4); put(16'd1, 16'd4); put(16'd2, 16'hFFFD); put(16'd4, 16'd5);
      put(16'hFFFD, 16'd10); put(16'hFFFE, 16'd11); put(16'hFFFF, 16'd7);
      put(16'd10, 16'd1); put(16'd11, 16'd5);
      load();
      run_one("tw_complete1", delta);
      check("tw_mem4", mem[4], 0);
      check("tw_pc1", pc, 16'hFFFD);
      check("tw_halted1", halted, 0);
      run_one("tw_complete2", delta);
      check("tw_waddr", wr_addr, 11);
      check("tw_mem11", mem[11], 4);
      check("tw_pc2", pc, 0);

      // 4) branch to the halt address
      do_reset();
      put(16'd0, 16'd4); put(16'd1, 16'd5); put(16'd2, 16'hFFFF);
      put(16'd4, 16'd1); put(16'd5, 16'd1);
      load();
      run = 1'b1;
      wait_halt("t4_halt");
      check("t4_pc", pc, 16'hFFFF);
      check("t4_mem5", mem[5], 0);
      reqs = 0;
      for (int i = 0; i < 20; i++) begin
         run = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (mem_req) reqs++;
      end
      run = 1'b0;
      check("t4_no_req", reqs, 0);
      check("t4_still_halted", halted, 1);
`ifdef SUBLEQ_INSTR_COUNT_EN
      check("t4_count", instr_count, 1);
`endif
      do_reset();
      check("t4_rst_halted", halted, 0);
      check("t4_rst_pc", pc, 0);
`ifdef SUBLEQ_INSTR_COUNT_EN
      check("t4_rst_count", instr_count, 0);
`endif

      // 5) three-instruction program, zero-wait then random ack delays
      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         rnd_mode = (pass == 1);
         prog_multi();
         w0  = wr_cnt;
         run = 1'b1;
         wait_halt(pass == 0 ? "t5_halt_zw" : "t5_halt_rnd");
         run = 1'b0;
         check("t5_mem21", mem[21], 3);
         check("t5_mem22", mem[22], 16'hFFFF);
         check("t5_mem23", mem[23], 0);
         check("t5_writes", wr_cnt - w0, 3);
         check("t5_pc", pc, 16'hFFFF);
`ifdef SUBLEQ_INSTR_COUNT_EN
         check("t5_count", instr_count, 3);
`endif
      end
      rnd_mode = 1'b0;

      // 6) run dropped during LOAD_A: instruction still completes, then idle
      do_reset();
      prog_basic(16'd3, 16'd7);
      a0  = acc_cnt;
      w0  = wr_cnt;
      run = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (acc_cnt >= a0 + 3) break;
         @(negedge clk);
      end
      check("t6_fetched", acc_cnt - a0, 3);
      run = 1'b0;
      wait_wr(w0, "t6_complete");
      reqs = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (mem_req) reqs++;
      end
      check("t6_idle_no_req", reqs, 0);
      check("t6_pc", pc, 3);
      check("t6_mem5", mem[5], 4);
      check("t6_halted", halted, 0);
`ifdef SUBLEQ_INSTR_COUNT_EN
      check("t6_count", instr_count, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1);
   end

endmodule
